// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit that maps byte/half/word accesses, aligned or not, onto word-wide memory cycles.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned accesses return err_o instead of being split.
module lsu_ctrl #(
  parameter int REG_SIZE = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [2:0]          funct3_i,
  input  logic [REG_SIZE-1:0] addr_i,
  input  logic [REG_SIZE-1:0] wdata_i,
  output logic                ready_o,
  output logic                valid_o,
  output logic [REG_SIZE-1:0] rdata_o,
  output logic                err_o,
  output logic                mem_we_o,
  output logic [REG_SIZE-1:0] mem_addr_o,
  output logic [REG_SIZE-1:0] mem_wdata_o,
  input  logic [REG_SIZE-1:0] mem_rdata_i
);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

  state_t      state_reg;
  logic        we_reg;
  logic        span_reg;
  logic [2:0]  funct3_reg;
  logic [1:0]  off_reg;
  logic [29:0] word_reg;
  logic [31:0] wdata_reg;
  logic [31:0] lo_reg;
  logic [31:0] hi_reg;
  logic [31:0] merged_hi_reg;
  logic        valid_reg;
  logic        err_reg;
  logic        mem_we_reg;
  logic [31:0] rdata_reg;
  logic [31:0] mem_addr_reg;
  logic [31:0] mem_wdata_reg;

  logic [1:0]  req_off;
  logic [2:0]  req_size;
  logic        req_span;
  logic        req_legal;
  logic        req_trap;
  logic        req_sw_aligned;

  assign req_off        = addr_i[1:0];
  assign req_size       = (funct3_i[1:0] == 2'b00) ? 3'd1 :
                          (funct3_i[1:0] == 2'b01) ? 3'd2 : 3'd4;
  assign req_span       = ({1'b0, req_off} + req_size) > 3'd4;
  assign req_legal      = we_i ? (funct3_i inside {3'b000, 3'b001, 3'b010})
                               : (funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign req_sw_aligned = we_i && (funct3_i == 3'b010) && (req_off == 2'b00);

`ifdef LSU_MISALIGN_TRAP_EN
  logic req_misalign;
  assign req_misalign = ((req_size == 3'd2) && req_off[0]) ||
                        ((req_size == 3'd4) && (req_off != 2'b00));
  assign req_trap     = !req_legal || req_misalign;
`else
  assign req_trap     = !req_legal;
`endif

  logic [31:0] wlo;
  logic [31:0] whi;
  logic [31:0] cur_lo;
  logic [31:0] cur_hi;
  logic [63:0] old64;
  logic [31:0] ld_word;
  logic [31:0] load_result;
  logic [7:0]  size_mask;
  logic [7:0]  byte_mask;
  logic [63:0] wshift;
  logic [63:0] merged;

  assign wlo = {word_reg, 2'b00};
  assign whi = {word_reg + 30'd1, 2'b00};

  // The word being read this cycle is used directly so the FSM needs no extra capture state.
  assign cur_lo = (state_reg == RD_LO) ? mem_rdata_i : lo_reg;
  assign cur_hi = (state_reg == RD_HI) ? mem_rdata_i : hi_reg;
  assign old64  = {cur_hi, cur_lo};

  always_comb begin
    case (off_reg)
      2'd0:    ld_word = old64[31:0];
      2'd1:    ld_word = old64[39:8];
      2'd2:    ld_word = old64[47:16];
      default: ld_word = old64[55:24];
    endcase
  end

  always_comb begin
    case (funct3_reg)
      3'b000:  load_result = {{24{ld_word[7]}}, ld_word[7:0]};
      3'b001:  load_result = {{16{ld_word[15]}}, ld_word[15:0]};
      3'b010:  load_result = ld_word;
      3'b100:  load_result = {24'h0, ld_word[7:0]};
      3'b101:  load_result = {16'h0, ld_word[15:0]};
      default: load_result = 32'h0;
    endcase
  end

  assign size_mask = (funct3_reg[1:0] == 2'b00) ? 8'h01 :
                     (funct3_reg[1:0] == 2'b01) ? 8'h03 : 8'h0F;
  assign byte_mask = size_mask << off_reg;
  assign wshift    = {32'h0, wdata_reg} << {off_reg, 3'b000};

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_merge
      assign merged[8*gi +: 8] = byte_mask[gi] ? wshift[8*gi +: 8] : old64[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg     <= IDLE;
      we_reg        <= 1'b0;
      span_reg      <= 1'b0;
      funct3_reg    <= 3'b000;
      off_reg       <= 2'b00;
      word_reg      <= 30'h0;
      wdata_reg     <= 32'h0;
      lo_reg        <= 32'h0;
      hi_reg        <= 32'h0;
      merged_hi_reg <= 32'h0;
      valid_reg     <= 1'b0;
      err_reg       <= 1'b0;
      mem_we_reg    <= 1'b0;
      rdata_reg     <= 32'h0;
      mem_addr_reg  <= 32'h0;
      mem_wdata_reg <= 32'h0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_i) begin
            we_reg     <= we_i;
            span_reg   <= req_span;
            funct3_reg <= funct3_i;
            off_reg    <= req_off;
            word_reg   <= addr_i[31:2];
            wdata_reg  <= wdata_i;
            if (req_trap) begin
              state_reg <= DONE;
              valid_reg <= 1'b1;
              err_reg   <= 1'b1;
              rdata_reg <= 32'h0;
            end else if (req_sw_aligned) begin
              state_reg     <= WR_LO;
              mem_we_reg    <= 1'b1;
              mem_addr_reg  <= {addr_i[31:2], 2'b00};
              mem_wdata_reg <= wdata_i;
            end else begin
              state_reg    <= RD_LO;
              mem_addr_reg <= {addr_i[31:2], 2'b00};
            end
          end
        end
        RD_LO: begin
          lo_reg <= mem_rdata_i;
          if (span_reg) begin
            state_reg    <= RD_HI;
            mem_addr_reg <= whi;
          end else if (we_reg) begin
            state_reg     <= WR_LO;
            mem_we_reg    <= 1'b1;
            mem_addr_reg  <= wlo;
            mem_wdata_reg <= merged[31:0];
          end else begin
            state_reg    <= DONE;
            valid_reg    <= 1'b1;
            err_reg      <= 1'b0;
            rdata_reg    <= load_result;
            mem_addr_reg <= 32'h0;
          end
        end
        RD_HI: begin
          hi_reg <= mem_rdata_i;
          if (we_reg) begin
            state_reg     <= WR_LO;
            mem_we_reg    <= 1'b1;
            mem_addr_reg  <= wlo;
            mem_wdata_reg <= merged[31:0];
            merged_hi_reg <= merged[63:32];
          end else begin
            state_reg    <= DONE;
            valid_reg    <= 1'b1;
            err_reg      <= 1'b0;
            rdata_reg    <= load_result;
            mem_addr_reg <= 32'h0;
          end
        end
        WR_LO: begin
          if (span_reg) begin
            state_reg     <= WR_HI;
            mem_addr_reg  <= whi;
            mem_wdata_reg <= merged_hi_reg;
          end else begin
            state_reg    <= DONE;
            mem_we_reg   <= 1'b0;
            mem_addr_reg <= 32'h0;
            valid_reg    <= 1'b1;
            err_reg      <= 1'b0;
            rdata_reg    <= 32'h0;
          end
        end
        WR_HI: begin
          state_reg    <= DONE;
          mem_we_reg   <= 1'b0;
          mem_addr_reg <= 32'h0;
          valid_reg    <= 1'b1;
          err_reg      <= 1'b0;
          rdata_reg    <= 32'h0;
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign ready_o     = (state_reg == IDLE);
  assign valid_o     = valid_reg;
  assign rdata_o     = rdata_reg;
  assign err_o       = err_reg;
  // Gated so no write can slip out in the cycle a reset is being applied.
  assign mem_we_o    = mem_we_reg & rst_ni;
  assign mem_addr_o  = mem_addr_reg;
  assign mem_wdata_o = mem_wdata_reg;

endmodule
